// File: rtl/clk_div_sched.sv
// clk_div_sched -- run-time controller for one programmable clock divider.
//
// Owns the divide counter and sequences divisor changes so that a new ratio
// only takes effect on a period boundary: div_out never shows a truncated
// period or a glitch. Start and stop are glitch-free, and the divisor in
// effect is reported on cur_div.
//
// Optional feature macro: CLK_DIV_SCHED_SWEEP_EN
//   When defined, adds the sweep_en input and the parameters SWEEP_PERIODS
//   and SWEEP_MAX. While sweeping in RUN, the divisor doubles every
//   SWEEP_PERIODS periods and wraps from SWEEP_MAX back to 2.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   run_en     in   level: 1 = run, 0 = stop at the end of the current period
//   cfg_valid  in   new divisor offered
//   cfg_ready  out  controller can accept a divisor
//   cfg_div    in   requested divisor (values below 2 are stored as 2)
//   div_out    out  divided clock (registered)
//   tick       out  one-cycle pulse on the first cycle of every period (registered)
//   busy       out  1 while in RUN or DRAIN (registered)
//   cur_div    out  divisor currently in effect
//   sweep_en   in   (sweep build only) enable the automatic divisor sweep
//
// Config handshake: a divisor transfers on any rising clk edge where
// cfg_valid && cfg_ready; cfg_div is sampled only then. cfg_ready is low while
// a divisor is waiting for the next period boundary, so at most one change
// can be pending at a time.
module clk_div_sched #(
  parameter int WIDTH         = 28,
  parameter int DEFAULT_DIV   = 4
`ifdef CLK_DIV_SCHED_SWEEP_EN
  ,
  parameter int SWEEP_PERIODS = 4,
  parameter int SWEEP_MAX     = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             div_out,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div
`ifdef CLK_DIV_SCHED_SWEEP_EN
  ,
  input  logic             sweep_en
`endif
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] active, active_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic             pend, pend_nxt;
  logic             div_nxt, tick_nxt, busy_nxt;

  logic             xfer;
  logic             tc;
  logic [WIDTH-1:0] cfg_clamped;

  assign tc          = (cnt == active - WIDTH'(1));
  assign cfg_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
  assign xfer        = cfg_valid && cfg_ready;
  assign cur_div     = active;

`ifdef CLK_DIV_SCHED_SWEEP_EN
  localparam int               PW       = (SWEEP_PERIODS > 1) ? $clog2(SWEEP_PERIODS) : 1;
  localparam logic [PW-1:0]    PCNT_END = PW'(SWEEP_PERIODS - 1);
  localparam logic [WIDTH-1:0] SMAX     = WIDTH'(SWEEP_MAX);

  logic          sweep_on;
  logic          sweep_step;
  logic [PW-1:0] pcnt, pcnt_nxt;

  assign sweep_on   = sweep_en && (state == ST_RUN);
  // A pending config change wins over a sweep step at the same boundary.
  assign sweep_step = sweep_on && tc && !pend && (pcnt == PCNT_END);
  assign cfg_ready  = !pend && !sweep_on;

  always_comb begin
    pcnt_nxt = '0;
    if (sweep_on) begin
      pcnt_nxt = pcnt;
      if (tc) begin
        pcnt_nxt = (pend || pcnt == PCNT_END) ? '0 : pcnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= pcnt_nxt;
  end
`else
  assign cfg_ready = !pend;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  // Next-state logic. Leaving RUN at a terminal count skips DRAIN: that
  // period has already ended normally.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  state_nxt = run_en ? ST_RUN : ST_STOP;
      ST_RUN:   if (!run_en) state_nxt = tc ? ST_STOP : ST_DRAIN;
      ST_DRAIN: begin
        if (run_en)  state_nxt = ST_RUN;
        else if (tc) state_nxt = ST_STOP;
      end
      default:  state_nxt = ST_STOP;
    endcase
  end

  // Output and datapath next values. The registered outputs lag cnt by one cycle.
  always_comb begin
    cnt_nxt    = cnt;
    active_nxt = active;
    shadow_nxt = shadow;
    pend_nxt   = pend;
    div_nxt    = 1'b0;
    tick_nxt   = 1'b0;
    busy_nxt   = (state_nxt != ST_STOP);
    case (state)
      ST_STOP: begin
        cnt_nxt = '0;
        if (xfer) begin
          active_nxt = cfg_clamped;
          shadow_nxt = cfg_clamped;
        end
      end
      default: begin
        div_nxt  = (cnt < (active >> 1));
        tick_nxt = (cnt == '0);
        if (tc) begin
          cnt_nxt = '0;
          // A transfer landing on the boundary applies immediately, with no
          // pending stall. It cannot coincide with pend because cfg_ready=!pend.
          if (xfer) begin
            active_nxt = cfg_clamped;
            shadow_nxt = cfg_clamped;
          end else if (pend) begin
            active_nxt = shadow;
            pend_nxt   = 1'b0;
          end
`ifdef CLK_DIV_SCHED_SWEEP_EN
          else if (sweep_step) begin
            // ">=" keeps a non-power-of-two start value from running past the top.
            active_nxt = (active >= SMAX) ? MIN_DIV : (active << 1);
            shadow_nxt = (active >= SMAX) ? MIN_DIV : (active << 1);
          end
`endif
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
          if (xfer) begin
            shadow_nxt = cfg_clamped;
            pend_nxt   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      active  <= DEF_DIV;
      shadow  <= DEF_DIV;
      pend    <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      shadow  <= shadow_nxt;
      pend    <= pend_nxt;
      div_out <= div_nxt;
      tick    <= tick_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched -- bench for clk_div_sched (default build).
// A period-level reference model predicts the registered outputs after every
// edge. The predictions go into a scoreboard queue, and each prediction is
// compared with the DUT on the following falling edge.
module tb_clk_div_sched;
  localparam int WIDTH       = 28;
  localparam int DEFAULT_DIV = 4;
  localparam int W           = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic             div_out;
  logic             tick;
  logic             busy;
  logic [WIDTH-1:0] cur_div;
`ifdef CLK_DIV_SCHED_SWEEP_EN
  logic             sweep_en = 1'b0;
`endif

  // Clock and reset block
  always #5 clk = ~clk;

  clk_div_sched #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .div_out   (div_out),
    .tick      (tick),
    .busy      (busy),
    .cur_div   (cur_div)
`ifdef CLK_DIV_SCHED_SWEEP_EN
    ,
    .sweep_en  (sweep_en)
`endif
  );

  // Scoreboard: {cur_div, cfg_ready, busy, tick, div_out}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: period-level view of the divider
  bit m_running;
  int m_pos;       // position inside the current period before the edge
  int m_div;       // divisor in effect
  bit m_pend;
  int m_pend_div;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_running  = 1'b0;
    m_pos      = 0;
    m_div      = DEFAULT_DIV;
    m_pend     = 1'b0;
    m_pend_div = DEFAULT_DIV;
    exp_q.delete();
  endtask

  // One rising edge with inputs r/v/d. Period position i yields div_out=(i<D/2),
  // tick=(i==0) on the edge that leaves it.
  task automatic model_edge(input bit r, input bit v, input int d);
    bit xfer;
    bit o_div, o_tick, o_busy;
    xfer = v && !m_pend;
    if (!m_running) begin
      o_div  = 1'b0;
      o_tick = 1'b0;
      o_busy = r;
      if (xfer) m_div = clamp(d);
      m_running = r;
      m_pos     = 0;
    end else begin
      o_div  = (m_pos < m_div / 2);
      o_tick = (m_pos == 0);
      o_busy = 1'b1;
      if (m_pos == m_div - 1) begin
        m_pos = 0;
        if (xfer) m_div = clamp(d);
        else if (m_pend) begin
          m_div  = m_pend_div;
          m_pend = 1'b0;
        end
        if (!r) begin
          m_running = 1'b0;
          o_busy    = 1'b0;
        end
      end else begin
        m_pos++;
        if (xfer) begin
          m_pend     = 1'b1;
          m_pend_div = clamp(d);
        end
      end
    end
    exp_q.push_back({WIDTH'(m_div), !m_pend, o_busy, o_tick, o_div});
  endtask

  // Driver: called at a falling edge; drives one cycle and checks the result
  task automatic step(input bit r, input bit v, input int d);
    logic [W-1:0] e;
    run_en    = r;
    cfg_valid = v;
    cfg_div   = WIDTH'(d);
    @(posedge clk);
    model_edge(r, v, d);
    @(negedge clk);
    e = exp_q.pop_front();
    check("div_out",   W'(div_out),   W'(e[0]));
    check("tick",      W'(tick),      W'(e[1]));
    check("busy",      W'(busy),      W'(e[2]));
    check("cfg_ready", W'(cfg_ready), W'(e[3]));
    check("cur_div",   W'(cur_div),   W'(e[W-1:4]));
  endtask

  // Step with run_en=r until the model sits at period position target
  task automatic run_until(input int target, input bit r);
    int guard;
    guard = 0;
    while (!(m_running && m_pos == target) && guard <= 64) begin
      step(r, 1'b0, 0);
      guard++;
    end
    if (guard > 64) check("wait_timeout", W'(guard), W'(64));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_div_out"},   W'(div_out),   W'(0));
    check({tag, "_tick"},      W'(tick),      W'(0));
    check({tag, "_busy"},      W'(busy),      W'(0));
    check({tag, "_cfg_ready"}, W'(cfg_ready), W'(1));
    check({tag, "_cur_div"},   W'(cur_div),   W'(DEFAULT_DIV));
  endtask

  initial begin
    rst       = 1'b1;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Default divisor 4 from reset
    repeat (12) step(1'b1, 1'b0, 0);

    // Mid-period change to 6: current period completes, then 3 high / 3 low
    run_until(1, 1'b1);
    step(1'b1, 1'b1, 6);
    repeat (16) step(1'b1, 1'b0, 0);

    // Change to 3 exactly on the terminal count, then 0 (stored as 2) on a TC
    run_until(m_div - 1, 1'b1);
    step(1'b1, 1'b1, 3);
    repeat (9) step(1'b1, 1'b0, 0);
    run_until(m_div - 1, 1'b1);
    step(1'b1, 1'b1, 0);
    repeat (8) step(1'b1, 1'b0, 0);

    // Divisor 8: drop run_en at position 1 and drain to STOP
    run_until(m_div - 1, 1'b1);
    step(1'b1, 1'b1, 8);
    run_until(1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 0);
    // Restart, drop at position 1, reassert at position 5: no break
    run_until(1, 1'b1);
    run_until(5, 1'b0);
    repeat (16) step(1'b1, 1'b0, 0);

    // Asynchronous reset in the middle of a high phase
    run_until(1, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit r, v;
      int d;
      r = ($urandom_range(0, 7) != 0);
      v = ($urandom_range(0, 3) == 0);
      d = $urandom_range(0, 9);
      step(r, v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
